// File: rtl/fec_cc_encoder_if.sv
// Serial bit-stream handshake bundle between upstream source, the encoder and the interleaver.
// The encoder connects through the slave modport; the producer/consumer side uses master.
interface fec_cc_encoder_if;
  logic Valid_in;
  logic Data_in;
  logic Ready_out;
  logic Ready_in;
  logic Valid_out;
  logic Data_out;

  modport master (
    output Valid_in,
    output Data_in,
    input  Ready_out,
    output Ready_in,
    input  Valid_out,
    input  Data_out
  );

  modport slave (
    input  Valid_in,
    input  Data_in,
    output Ready_out,
    input  Ready_in,
    output Valid_out,
    output Data_out
  );
endinterface

// File: rtl/fec_cc_encoder.sv
// Rate-1/2 tail-biting convolutional encoder (K=7, G1=171o, G2=133o) with ping-pong
// 96-bit block buffers: one buffer fills from the serial input while the other is encoded.
module fec_cc_encoder #(
  parameter int BLK_BITS = 96
) (
  input  logic              clk,
  input  logic              rstn,
  fec_cc_encoder_if.slave   bus
);

  localparam int CW = $clog2(BLK_BITS);
  localparam logic [CW-1:0] LAST = CW'(BLK_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    EMIT    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                readyEn_q;
  logic [1:0]          full_q, full_d;
  logic                wrSel_q, wrSel_d;
  logic                rdSel_q, rdSel_d;
  logic [CW-1:0]       wrCnt_q, wrCnt_d;
  logic [CW-1:0]       rdCnt_q, rdCnt_d;
  logic                phase_q, phase_d;
  logic [5:0]          s_q, s_d;
  logic [BLK_BITS-1:0] buf_q [2];

  logic                ready;
  logic                wrFire;
  logic                wrLast;
  logic [BLK_BITS-1:0] rdBuf;
  logic                rdOther;
  logic                u;
  logic                xBit;
  logic                yBit;
  logic                emitting;
  logic                accept;
  logic                rdLast;

  // readyEn_q keeps Ready_out low until the first edge after reset release.
  assign ready    = readyEn_q && !full_q[wrSel_q];
  assign wrFire   = bus.Valid_in && ready;
  assign wrLast   = wrFire && (wrCnt_q == LAST);

  assign rdBuf    = buf_q[rdSel_q];
  assign rdOther  = ~rdSel_q;
  assign u        = rdBuf[rdCnt_q];
  assign xBit     = u ^ s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[5];
  assign yBit     = u ^ s_q[1] ^ s_q[2] ^ s_q[4] ^ s_q[5];

  // The encoder state registers act as the output stage: they only move when the
  // presented bit is taken, so a stall freezes Data_out/Valid_out for free.
  assign emitting = (state_q == EMIT);
  assign accept   = emitting && (!bus.Valid_out || bus.Ready_in);
  assign rdLast   = accept && phase_q && (rdCnt_q == LAST);

  assign bus.Ready_out = ready;
  assign bus.Valid_out = emitting;
  assign bus.Data_out  = emitting && (phase_q ? yBit : xBit);

  always_comb begin
    wrCnt_d = wrCnt_q;
    wrSel_d = wrSel_q;
    full_d  = full_q;
    if (wrFire) begin
      if (wrLast) begin
        wrCnt_d = '0;
        wrSel_d = ~wrSel_q;
      end else begin
        wrCnt_d = wrCnt_q + CW'(1);
      end
    end
    // Set and clear always target different buffers, so both may happen on one edge.
    if (wrLast) full_d[wrSel_q] = 1'b1;
    if (rdLast) full_d[rdSel_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    rdSel_d = rdSel_q;
    rdCnt_d = rdCnt_q;
    phase_d = phase_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (full_q[rdSel_q]) state_d = PRELOAD;
      end
      PRELOAD: begin
        // Tail-biting start: the register holds the last six bits of the block.
        for (int k = 0; k < 6; k++) s_d[k] = rdBuf[BLK_BITS-1-k];
        rdCnt_d = '0;
        phase_d = 1'b0;
        state_d = EMIT;
      end
      EMIT: begin
        if (accept) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            s_d     = {s_q[4:0], u};
            if (rdCnt_q == LAST) begin
              rdCnt_d = '0;
              rdSel_d = rdOther;
              state_d = full_d[rdOther] ? PRELOAD : IDLE;
            end else begin
              rdCnt_d = rdCnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      readyEn_q <= 1'b0;
      full_q    <= '0;
      wrSel_q   <= 1'b0;
      rdSel_q   <= 1'b0;
      wrCnt_q   <= '0;
      rdCnt_q   <= '0;
      phase_q   <= 1'b0;
      s_q       <= '0;
    end else begin
      state_q   <= state_d;
      readyEn_q <= 1'b1;
      full_q    <= full_d;
      wrSel_q   <= wrSel_d;
      rdSel_q   <= rdSel_d;
      wrCnt_q   <= wrCnt_d;
      rdCnt_q   <= rdCnt_d;
      phase_q   <= phase_d;
      s_q       <= s_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (wrFire) begin
      buf_q[wrSel_q][wrCnt_q] <= bus.Data_in;
    end
  end

endmodule
